sha256_nonce_sequencer: RTL and testbench

// Drives the sha256_transform pipeline and consumes its result: accepts a work unit (midstate, header tail, nonce range),

---
 rtl/sha256_nonce_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_sha256_nonce_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_nonce_sequencer.sv
// Nonce sequencer for a folded sha256_transform: issues one padded block per nonce every LOOP cycles,
// tracks in-flight hashes, compares each returned hash against a target and reports golden nonces.
module sha256_nonce_sequencer #(
    parameter int LOOP         = 4,
    parameter int HASH_LATENCY = 65
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] work_state,
    input  logic [95:0]  work_data,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [31:0]  target,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic [5:0]   hs_cnt,
    output logic         hs_feedback,
    output logic [255:0] hs_state,
    output logic [511:0] hs_input,
    input  logic [255:0] tx_hash,
    output logic         golden_valid,
    input  logic         golden_ready,
    output logic [31:0]  golden_nonce,
    output logic         golden_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'(LOOP - 1);

    state_t                    state_r;
    logic [5:0]                cnt_r;
    logic                      feedback_r;
    logic                      work_ready_r;
    logic                      busy_r;
    logic                      done_r;
    logic [255:0]              mid_r;
    logic [95:0]               data_r;
    logic [31:0]               issue_nonce_r;
    logic [31:0]               end_r;
    logic [31:0]               check_nonce_r;
    logic [31:0]               target_r;
    logic [HASH_LATENCY-1:0]   trk_r;
    logic                      golden_valid_r;
    logic [31:0]               golden_nonce_r;
    logic                      golden_ovf_r;

    logic [5:0]                cnt_next_s;
    logic                      issue_s;
    logic                      check_s;
    logic                      hit_s;
    logic                      take_s;
    logic                      unused_s;

    assign cnt_next_s = (cnt_r == CNT_LAST) ? 6'd0 : cnt_r + 6'd1;
    assign issue_s    = (state_r == ST_RUN) && (cnt_r == 6'd0);
    // The tail bit marks the cycle where tx_hash belongs to check_nonce; an abort discards that result.
    assign check_s    = trk_r[HASH_LATENCY-1] && !abort;
    assign hit_s      = check_s && (tx_hash[255:224] <= target_r);
    assign take_s     = golden_valid_r && golden_ready;
    assign unused_s   = ^tx_hash[223:0];

    assign work_ready   = work_ready_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign hs_cnt       = cnt_r;
    assign hs_feedback  = feedback_r;
    assign hs_state     = mid_r;
    assign hs_input     = {32'h0000_0280, 320'd0, 32'h8000_0000, issue_nonce_r, data_r};
    assign golden_valid = golden_valid_r;
    assign golden_nonce = golden_nonce_r;
    assign golden_ovf   = golden_ovf_r;

    // Free-running transform round counter and its feedback select.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r      <= 6'd0;
            feedback_r <= 1'b0;
        end else begin
            cnt_r      <= cnt_next_s;
            feedback_r <= (cnt_next_s != 6'd0);
        end
    end

    // Work-unit FSM: latches work, issues nonces, tracks in-flight hashes and signals completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            work_ready_r  <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            mid_r         <= 256'd0;
            data_r        <= 96'd0;
            issue_nonce_r <= 32'd0;
            end_r         <= 32'd0;
            check_nonce_r <= 32'd0;
            target_r      <= 32'd0;
            trk_r         <= '0;
        end else if (abort) begin
            state_r      <= ST_IDLE;
            work_ready_r <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            trk_r        <= '0;
        end else begin
            done_r <= 1'b0;
            trk_r  <= {trk_r[HASH_LATENCY-2:0], issue_s};
            if (check_s) begin
                check_nonce_r <= check_nonce_r + 32'd1;
            end else begin
                check_nonce_r <= check_nonce_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (work_valid) begin
                        mid_r         <= work_state;
                        data_r        <= work_data;
                        issue_nonce_r <= nonce_start;
                        check_nonce_r <= nonce_start;
                        end_r         <= nonce_end;
                        target_r      <= target;
                        state_r       <= ST_RUN;
                        work_ready_r  <= 1'b0;
                        busy_r        <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // Compare before incrementing so the range may wrap through 2^32.
                    if (cnt_r == 6'd0) begin
                        issue_nonce_r <= issue_nonce_r + 32'd1;
                        if (issue_nonce_r == end_r) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (trk_r == '0) begin
                        state_r      <= ST_IDLE;
                        work_ready_r <= 1'b1;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    work_ready_r <= 1'b1;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    // Golden nonce holding register with sticky overflow when a hit finds it occupied.
    always_ff @(posedge clk) begin
        if (reset) begin
            golden_valid_r <= 1'b0;
            golden_nonce_r <= 32'd0;
            golden_ovf_r   <= 1'b0;
        end else if (hit_s) begin
            if (!golden_valid_r || take_s) begin
                golden_valid_r <= 1'b1;
                golden_nonce_r <= check_nonce_r;
            end else begin
                golden_ovf_r <= 1'b1;
            end
        end else if (take_s) begin
            golden_valid_r <= 1'b0;
        end else begin
            golden_valid_r <= golden_valid_r;
        end
    end

endmodule

// File: tb/tb_sha256_nonce_sequencer.sv
// Directed bench for sha256_nonce_sequencer with a stub transform and a cycle-level reference model.
module tb_sha256_nonce_sequencer;
    localparam int LOOP = 4;
    localparam int HL   = 65;

    logic         clk = 1'b0;
    logic         reset, work_valid, abort, golden_ready;
    logic [255:0] work_state;
    logic [95:0]  work_data;
    logic [31:0]  nonce_start, nonce_end, target;
    logic         work_ready, busy, done, hs_feedback, golden_valid, golden_ovf;
    logic [5:0]   hs_cnt;
    logic [255:0] hs_state, tx_hash;
    logic [511:0] hs_input;
    logic [31:0]  golden_nonce;

    sha256_nonce_sequencer #(.LOOP(LOOP), .HASH_LATENCY(HL)) dut (
        .clk(clk), .reset(reset), .work_valid(work_valid), .work_ready(work_ready),
        .work_state(work_state), .work_data(work_data), .nonce_start(nonce_start),
        .nonce_end(nonce_end), .target(target), .abort(abort), .busy(busy), .done(done),
        .hs_cnt(hs_cnt), .hs_feedback(hs_feedback), .hs_state(hs_state), .hs_input(hs_input),
        .tx_hash(tx_hash), .golden_valid(golden_valid), .golden_ready(golden_ready),
        .golden_nonce(golden_nonce), .golden_ovf(golden_ovf)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] magic = 32'hDEAD_BEEF;
    logic [31:0] got_q[$];

    // Stand-in hash: top word is zero only for the magic nonce, otherwise has bit 31 set.
    function automatic logic [31:0] fake_top(input logic [31:0] n);
        if (n == magic) return 32'd0;
        return 32'h8000_0000 | (n * 32'h9E37_79B1);
    endfunction

    // Stub transform: the hash of the block presented in cycle T is visible from cycle T+HL.
    logic [255:0] pipe [0:HL-1];
    always @(posedge clk) begin
        pipe[0] <= {fake_top(hs_input[127:96]), {7{hs_input[127:96] ^ hs_state[31:0]}}};
        for (int i = 1; i < HL; i++) pipe[i] <= pipe[i-1];
    end
    assign tx_hash = pipe[HL-1];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state: expected outputs for the current cycle.
    typedef struct { longint due; logic [31:0] nonce; } fl_t;
    fl_t          m_q[$];
    bit           m_known = 1'b0;
    bit           m_active, m_done, m_gv, m_ovf, hit, take, empty_before;
    int           m_cnt;
    longint       m_rem;
    longint       cyc = 0;
    logic [31:0]  m_next, m_target, m_gn, hn, diff;
    logic [255:0] m_state;
    logic [95:0]  m_data;

    always @(negedge clk) begin
        if (m_known) begin
            chk("work_ready", work_ready, !m_active);
            chk("busy", busy, m_active);
            chk("done", done, m_done);
            chk("hs_cnt", hs_cnt, m_cnt);
            chk("hs_feedback", hs_feedback, m_cnt != 0);
            chk("golden_valid", golden_valid, m_gv);
            chk("golden_nonce", golden_nonce, m_gn);
            chk("golden_ovf", golden_ovf, m_ovf);
            if (m_active && m_rem > 0 && m_cnt == 0) begin
                chk("issue_nonce", hs_input[127:96], m_next);
                chk("issue_data", hs_input[95:0], m_data);
                chk("issue_word4", hs_input[159:128], 32'h8000_0000);
                chk("issue_pad", hs_input[479:160], 320'd0);
                chk("issue_word15", hs_input[511:480], 32'h0000_0280);
                chk("issue_state", hs_state, m_state);
            end
        end
        if (reset) begin
            m_known = 1'b1; m_cnt = 0; m_active = 1'b0; m_rem = 0; m_q.delete();
            m_done = 1'b0; m_gv = 1'b0; m_ovf = 1'b0; m_gn = 32'd0;
        end else begin
            hit = 1'b0;
            hn = 32'd0;
            m_done = 1'b0;
            if (abort) begin
                m_active = 1'b0; m_rem = 0; m_q.delete();
            end else begin
                empty_before = (m_q.size() == 0);
                if (!empty_before && m_q[0].due == cyc) begin
                    hn = m_q[0].nonce;
                    hit = (fake_top(hn) <= m_target);
                    void'(m_q.pop_front());
                end
                if (!m_active) begin
                    if (work_valid) begin
                        m_active = 1'b1; m_next = nonce_start; m_target = target;
                        m_data = work_data; m_state = work_state;
                        diff = nonce_end - nonce_start;
                        m_rem = longint'(diff) + 1;
                    end
                end else if (m_rem > 0) begin
                    if (m_cnt == 0) begin
                        m_q.push_back('{cyc + HL, m_next});
                        m_next = m_next + 32'd1;
                        m_rem--;
                    end
                end else if (empty_before) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end
            end
            take = m_gv && golden_ready;
            if (hit) begin
                if (!m_gv || take) begin m_gv = 1'b1; m_gn = hn; end
                else m_ovf = 1'b1;
            end else if (take) begin
                m_gv = 1'b0;
            end
            m_cnt = (m_cnt + 1) % LOOP;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (golden_valid && golden_ready) got_q.push_back(golden_nonce);
    end

    task automatic start_work(input logic [31:0] s, input logic [31:0] e, input logic [31:0] t);
        @(posedge clk); #1;
        nonce_start = s; nonce_end = e; target = t;
        work_state = {8{s ^ 32'h1234_5678}}; work_data = {e, s, 32'hCAFE_0000 ^ t};
        work_valid = 1'b1;
        @(posedge clk); #1;
        work_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int dones);
        bit idle;
        idle = 1'b0;
        dones = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (!busy) begin idle = 1'b1; break; end
        end
        if (!idle) begin
            vectors++; miscompares++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", budget);
        end
    endtask

    task automatic chk_list(input string name, input int n, input logic [31:0] e0,
                            input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) chk(name, got_q[i], e[i]);
    endtask

    task automatic pulse_ready();
        @(posedge clk); #1 golden_ready = 1'b1;
        @(posedge clk); #1 golden_ready = 1'b0;
    endtask

    int d, dc, gc;
    logic [31:0] t20;

    initial begin
        reset = 1'b1; work_valid = 1'b0; abort = 1'b0; golden_ready = 1'b0;
        work_state = 256'd0; work_data = 96'd0;
        nonce_start = 32'd0; nonce_end = 32'd0; target = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("cnt_after_reset", hs_cnt, i % 4);
        end
        chk("reset_ready", work_ready, 1'b1);
        chk("reset_golden_valid", golden_valid, 1'b0);

        // Single nonce, golden held until released.
        start_work(32'd5, 32'd5, 32'hFFFF_FFFF);
        wait_idle(300, d);
        chk("single_done_pulses", d, 1);
        chk("single_golden", golden_nonce, 32'd5);
        pulse_ready();

        // Consumer stalled: first hit held, second sets overflow.
        start_work(32'd10, 32'd13, 32'hFFFF_FFFF);
        wait_idle(300, d);
        chk("ovf_golden_held", golden_nonce, 32'd10);
        chk("ovf_sticky", golden_ovf, 1'b1);
        pulse_ready();

        golden_ready = 1'b1;
        got_q.delete();
        start_work(32'd10, 32'd13, 32'hFFFF_FFFF);
        wait_idle(300, d);
        chk_list("ready_stream", 4, 32'd10, 32'd11, 32'd12, 32'd13);

        got_q.delete();
        start_work(32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF);
        wait_idle(300, d);
        chk_list("wrap_stream", 4, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1);

        // Target zero: only the magic nonce qualifies.
        magic = 32'h0000_0123;
        got_q.delete();
        start_work(32'h0000_0120, 32'h0000_0127, 32'd0);
        wait_idle(300, d);
        chk_list("target_zero", 1, 32'h0000_0123, 32'd0, 32'd0, 32'd0);
        magic = 32'hDEAD_BEEF;

        // Unsigned compare boundary: equal hits, one below misses.
        t20 = fake_top(32'd20);
        got_q.delete();
        start_work(32'd20, 32'd20, t20);
        wait_idle(300, d);
        chk_list("target_equal", 1, 32'd20, 32'd0, 32'd0, 32'd0);
        got_q.delete();
        start_work(32'd20, 32'd20, t20 - 32'd1);
        wait_idle(300, d);
        chk_list("target_below", 0, 32'd0, 32'd0, 32'd0, 32'd0);

        // Abort beats work_valid in IDLE.
        @(posedge clk); #1 abort = 1'b1; work_valid = 1'b1;
        @(posedge clk); #1 abort = 1'b0; work_valid = 1'b0;
        @(negedge clk);
        chk("abort_blocks_accept", busy, 1'b0);

        // Abort mid-run, then a fresh unit.
        got_q.delete();
        start_work(32'd200, 32'd300, 32'hFFFF_FFFF);
        repeat (12) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", busy, 1'b0);
        repeat (80) @(posedge clk);
        chk_list("abort_no_golden", 0, 32'd0, 32'd0, 32'd0, 32'd0);
        start_work(32'd100, 32'd100, 32'hFFFF_FFFF);
        wait_idle(300, d);
        chk_list("after_abort", 1, 32'd100, 32'd0, 32'd0, 32'd0);

        // Reset during drain.
        got_q.delete();
        start_work(32'd50, 32'd51, 32'hFFFF_FFFF);
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        dc = 0; gc = 0;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk);
            if (done) dc++;
            if (golden_valid) gc++;
        end
        chk("drain_reset_done", dc, 0);
        chk("drain_reset_golden", gc, 0);
        chk("drain_reset_ovf", golden_ovf, 1'b0);
        start_work(32'd7, 32'd7, 32'hFFFF_FFFF);
        wait_idle(300, d);
        chk("post_reset_done", d, 1);
        chk_list("post_reset", 1, 32'd7, 32'd0, 32'd0, 32'd0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog");
    end
endmodule
